wb_32to8_bridge: RTL and testbench
==================================

// Module: wb_32to8_bridge
// PURPOSE
//  Sits between the 32-bit VeeRwolf Wishbone interconnect and the 8-bit simple I2C register slave.
//  Splits each 32-bit classic-Wishbone access into one 8-bit downstream access per selected byte lane.
//  Reassembles read bytes into the 32-bit word; reports a stalled downstream slave via err_o (timeout).
// PARAMETERS
//  ADDR_W   6    downstream byte-address width (upstream word address = adr_i[ADDR_W-1:2])
//  TIMEOUT  255  max clocks to wait for m_ack_i per byte; 0 = timeout disabled (wait forever)
// PORTS
//  clk       in   1         clock
//  rst       in   1         synchronous reset, active-high
//  cyc_i     in   1         upstream cycle
//  stb_i     in   1         upstream strobe
//  we_i      in   1         upstream write enable
//  adr_i     in   ADDR_W-2  upstream word address (bits ADDR_W-1:2)
//  sel_i     in   4         byte-lane selects, lane k = bits 8k+7:8k
//  dat_i     in   32        upstream write data
//  dat_o     out  32        upstream read data
//  ack_o     out  1         upstream acknowledge (1-cycle pulse)
//  err_o     out  1         upstream error, downstream timeout (1-cycle pulse)
//  m_cyc_o   out  1         downstream cycle
//  m_stb_o   out  1         downstream strobe (1-cycle pulse per byte)
//  m_we_o    out  1         downstream write enable
//  m_adr_o   out  ADDR_W    downstream byte address
//  m_dat_o   out  8         downstream write data
//  m_dat_i   in   8         downstream read data
//  m_ack_i   in   1         downstream acknowledge
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, read-assembly and timeout counters cleared; applies mid-transfer too.
//  - FSM: IDLE -> STROBE -> WAIT -> (STROBE | RESP) -> IDLE. All outputs registered (Moore).
//  - IDLE: when cyc_i&stb_i, latch we_i/adr_i/sel_i/dat_i; clear dat_o.
//      sel_i==0: go to RESP, ack_o high next cycle, no downstream activity.
//      Else: select lowest set lane; go to STROBE.
//  - STROBE (1 cycle): m_cyc_o=1, m_stb_o=1, m_we_o=we, m_adr_o={adr,lane[1:0]}, m_dat_o=dat byte lane.
//  - WAIT: m_stb_o=0, m_cyc_o stays 1; timeout counter increments each cycle.
//  - m_ack_i is honoured in STROBE or WAIT only; ignored in IDLE/RESP.
//      Read: m_dat_i written into dat_o lane.
//      Next set lane (ascending) -> STROBE; none left -> RESP.
//  - Strobe is a single-cycle pulse so the registered-ack slave performs exactly one access per byte.
//  - Timeout: TIMEOUT!=0 and counter==TIMEOUT with no ack -> RESP with err_o=1, ack_o=0; remaining lanes skipped.
//      Counter is cleared on every STROBE.
//  - RESP (1 cycle): ack_o or err_o=1, m_cyc_o=0; dat_o holds assembled word (unselected lanes 0).
//      dat_o stays stable until the next accepted request.
//  - Latency, slave acking 1 clock after strobe: N = popcount(sel_i).
//      ack_o is high 2N+1 clocks after the request is sampled; 1 clock when N=0.
//  - Upstream cyc_i dropped mid-transfer: the in-flight byte completes (or times out).
//      Remaining lanes are skipped; RESP is suppressed (no ack_o/err_o); return to IDLE.
//  - Requests are not accepted in RESP, so a master holding stb_i during its ack cycle is not re-executed.
//  - Byte order little-endian: lane 0 -> lowest downstream address.
// TESTING
//  1 Reset with stb_i held high -> all outputs 0; m_stb_o never pulses while rst=1.
//  2 Write sel=0001 adr_i=0x2 dat=0x000000A5 -> one m_stb_o pulse, m_adr_o=0x08, m_dat_o=0xA5; ack_o at clock 3.
//  3 Read sel=1111 adr_i=0x3, slave returns 11,22,33,44 -> m_adr_o 0x0C..0x0F ascending; dat_o=0x44332211; ack_o at clock 9.
//  4 Write sel=0101 adr_i=0x4 dat=0xDEADBEEF -> exactly two writes, 0x10=0xEF then 0x12=0xAD; ack_o at clock 5.
//  5 TIMEOUT=8, slave never acks -> err_o one cycle after 8 WAIT clocks; no ack_o; m_cyc_o=0 in RESP.
//  6a sel=0 -> ack_o next clock with dat_o=0, no m_cyc_o.
//  6b rst in WAIT of a 4-lane read -> outputs 0 next clock; new request then runs normally.

Source files
------------

// File: rtl/wb_32to8_bridge.sv
// -----------------------------------------------------------------------------
// wb_32to8_bridge
//
// Bridges the 32-bit classic Wishbone interconnect to an 8-bit register slave.
// Each upstream access is split into one downstream byte access per selected
// byte lane, issued in ascending lane order (lane 0 = lowest byte address).
// Read bytes are reassembled into dat_o. A downstream slave that never acks is
// reported upstream through a one-cycle err_o pulse after TIMEOUT wait clocks.
//
// Parameters
//   ADDR_W   downstream byte-address width; upstream word address is ADDR_W-2 bits
//   TIMEOUT  wait clocks allowed per byte before err_o; 0 disables the timeout
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cyc_i, stb_i, we_i  upstream cycle / strobe / write enable
//   adr_i               upstream word address
//   sel_i               upstream byte-lane selects (lane k = bits 8k+7:8k)
//   dat_i / dat_o       upstream write data / assembled read data
//   ack_o, err_o        upstream acknowledge / timeout error (1-cycle pulses)
//   m_cyc_o, m_stb_o    downstream cycle / single-cycle strobe per byte
//   m_we_o              downstream write enable
//   m_adr_o, m_dat_o    downstream byte address / write data
//   m_dat_i, m_ack_i    downstream read data / acknowledge
//
// Handshake: a request is taken when cyc_i & stb_i are high in IDLE. The bridge
// answers with exactly one ack_o or err_o pulse (none if cyc_i was dropped
// mid-transfer). Downstream, each byte is one m_stb_o pulse inside m_cyc_o, and
// is complete on the first m_ack_i seen while that byte is outstanding.
// -----------------------------------------------------------------------------
module wb_32to8_bridge #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-3:0] adr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [7:0]        m_dat_o,
    input  logic [7:0]        m_dat_i,
    input  logic              m_ack_i
);

    localparam int               CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-3:0] adr_q;
    logic [31:0]       wdat_q;
    logic [3:0]        rem_q;     // lanes still to be issued
    logic [1:0]        lane_q;    // lane currently outstanding downstream
    logic [CNT_W-1:0]  cnt_q;     // wait clocks spent on the current byte
    logic              abort_q;   // upstream dropped cyc_i during this transfer

    logic [1:0]        req_lane_d;
    logic [1:0]        next_lane_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_d;
    logic              abort_d;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) l = 2'(k);
        end
        return l;
    endfunction

    always_comb begin
        req_lane_d  = low_lane(sel_i);
        next_lane_d = low_lane(rem_q);
        cnt_d       = cnt_q + CNT_W'(1);
        // Fires on the wait clock that brings the count up to TIMEOUT, so the
        // error response follows exactly TIMEOUT wait clocks without an ack.
        timeout_d   = (TIMEOUT != 0) && (cnt_d == TO_VAL);
        abort_d     = abort_q | ~cyc_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rem_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            dat_o   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            m_stb_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cyc_i && stb_i) begin
                        we_q    <= we_i;
                        adr_q   <= adr_i;
                        wdat_q  <= dat_i;
                        dat_o   <= '0;
                        abort_q <= 1'b0;
                        if (sel_i == 4'd0) begin
                            rem_q   <= '0;
                            ack_o   <= 1'b1;
                            state_q <= S_RESP;
                        end else begin
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= we_i;
                            m_adr_o <= {adr_i, req_lane_d};
                            m_dat_o <= dat_i[8*req_lane_d +: 8];
                            lane_q  <= req_lane_d;
                            rem_q   <= sel_i & ~(4'b0001 << req_lane_d);
                            cnt_q   <= '0;
                            state_q <= S_STROBE;
                        end
                    end
                end

                S_STROBE, S_WAIT: begin
                    abort_q <= abort_d;
                    if (m_ack_i || (state_q == S_WAIT && timeout_d)) begin
                        if (m_ack_i && !we_q) begin
                            dat_o[8*lane_q +: 8] <= m_dat_i;
                        end
                        if (abort_d) begin
                            // Upstream gave up: finish silently, skip the rest.
                            m_cyc_o <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (m_ack_i && rem_q != 4'd0) begin
                            m_stb_o <= 1'b1;
                            m_adr_o <= {adr_q, next_lane_d};
                            m_dat_o <= wdat_q[8*next_lane_d +: 8];
                            lane_q  <= next_lane_d;
                            rem_q   <= rem_q & ~(4'b0001 << next_lane_d);
                            cnt_q   <= '0;
                            state_q <= S_STROBE;
                        end else begin
                            // Either the last lane was acked or this byte timed
                            // out; a timeout abandons any remaining lanes.
                            m_cyc_o <= 1'b0;
                            ack_o   <= m_ack_i;
                            err_o   <= ~m_ack_i;
                            state_q <= S_RESP;
                        end
                    end else begin
                        if (state_q == S_WAIT) begin
                            cnt_q <= cnt_d;
                        end
                        state_q <= S_WAIT;
                    end
                end

                // One-cycle response slot; requests are not sampled here, so a
                // master still holding stb_i in its ack cycle is not re-run.
                S_RESP: state_q <= S_IDLE;

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_32to8_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_32to8_bridge
//
// Bench for wb_32to8_bridge (TIMEOUT = 8). A behavioural byte slave with a
// random per-byte ack delay sits downstream. The reference model predicts,
// from each upstream request alone, the ordered list of downstream byte
// accesses, the response kind, the assembled read word and the response
// latency; a single monitor compares the DUT against it on every clock.
// Latency is counted in clocks from the edge that samples the request to the
// edge at which the master sees ack_o/err_o.
// -----------------------------------------------------------------------------
module tb_wb_32to8_bridge;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              cyc_i;
    logic              stb_i;
    logic              we_i;
    logic [ADDR_W-3:0] adr_i;
    logic [3:0]        sel_i;
    logic [31:0]       dat_i;
    logic [31:0]       dat_o;
    logic              ack_o;
    logic              err_o;
    logic              m_cyc_o;
    logic              m_stb_o;
    logic              m_we_o;
    logic [ADDR_W-1:0] m_adr_o;
    logic [7:0]        m_dat_o;
    logic [7:0]        m_dat_i;
    logic              m_ack_i;

    int          n_cmp;
    int          n_bad;
    logic [14:0] exp_acc_q[$];   // {we, byte address, byte data}
    logic [32:0] exp_resp_q[$];  // {is_err, assembled word}
    int          dly_q[$];       // extra ack delay per downstream byte
    logic [7:0]  ref_mem[64];
    logic [7:0]  slv_mem[64];
    bit          slave_mute;
    bit          hold_valid;
    logic [31:0] hold_dat;
    logic        stb_prev;

    wb_32to8_bridge #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .sel_i  (sel_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .m_cyc_o(m_cyc_o),
        .m_stb_o(m_stb_o),
        .m_we_o (m_we_o),
        .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o),
        .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- downstream slave ----------------
    initial begin
        int         pend;
        int         cnt;
        int         d;
        logic [7:0] rd;
        logic [5:0] a;
        pend    = 0;
        cnt     = 0;
        rd      = '0;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 0;
                m_ack_i <= 1'b0;
            end else begin
                m_ack_i <= 1'b0;
                if (pend != 0) begin
                    if (cnt == 0) begin
                        m_ack_i <= 1'b1;
                        m_dat_i <= rd;
                        pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (m_cyc_o && m_stb_o && !slave_mute) begin
                    a = m_adr_o;
                    d = 0;
                    if (dly_q.size() > 0) d = dly_q.pop_front();
                    rd = slv_mem[a];
                    if (m_we_o) slv_mem[a] = m_dat_o;
                    if (d == 0) begin
                        m_ack_i <= 1'b1;
                        m_dat_i <= rd;
                    end else begin
                        pend = 1;
                        cnt  = d - 1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / compare ----------------
    initial begin
        logic [32:0] r;
        logic [14:0] e;
        stb_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("stb_during_rst", m_stb_o, 1'b0);
            end else begin
                if (m_stb_o) begin
                    chk("stb_outside_cyc", m_cyc_o, 1'b1);
                    chk("stb_not_single_pulse", stb_prev, 1'b0);
                    if (exp_acc_q.size() == 0) begin
                        chk("unexpected_strobe", {m_we_o, m_adr_o, m_dat_o}, 15'h7fff);
                    end else begin
                        e = exp_acc_q.pop_front();
                        chk("byte_access", {m_we_o, m_adr_o, m_dat_o}, e);
                    end
                end
                if (ack_o || err_o) begin
                    chk("ack_and_err", ack_o & err_o, 1'b0);
                    chk("resp_cyc", m_cyc_o, 1'b0);
                    if (exp_resp_q.size() == 0) begin
                        chk("unexpected_resp", {ack_o, err_o}, 2'b00);
                    end else begin
                        r = exp_resp_q.pop_front();
                        chk("resp_kind", {ack_o, err_o}, r[32] ? 2'b01 : 2'b10);
                        if (!r[32]) chk("resp_data", dat_o, r[31:0]);
                    end
                end
                if (hold_valid) chk("dat_hold", dat_o, hold_dat);
            end
            stb_prev = m_stb_o;
        end
    end

    // ---------------- driver tasks ----------------
    // Runs one upstream request and predicts everything it should cause.
    task automatic do_req(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int max_d, input bit mute,
                          output int lat, output logic [31:0] rdat,
                          output bit got_err, output bit saw_cyc);
        int          exp_lat;
        logic [31:0] exp_dat;
        bit          got;
        bit          first;
        int          d;
        logic [5:0]  a;
        exp_dat = '0;
        exp_lat = 1;
        first   = 1;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                a = {adr, 2'(k)};
                if (!mute) begin
                    d = $urandom_range(0, max_d);
                    dly_q.push_back(d);
                    exp_lat += 2 + d;
                    exp_acc_q.push_back({we, a, dat[8*k +: 8]});
                    if (we) ref_mem[a] = dat[8*k +: 8];
                    else    exp_dat[8*k +: 8] = ref_mem[a];
                end else if (first) begin
                    exp_acc_q.push_back({we, a, dat[8*k +: 8]});
                end
                first = 0;
            end
        end
        if (mute) exp_lat = 2 + TIMEOUT;
        exp_resp_q.push_back({mute, exp_dat});

        @(negedge clk);
        hold_valid = 0;
        slave_mute = mute;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        sel_i = sel;
        dat_i = dat;
        lat     = 0;
        got     = 0;
        got_err = 0;
        saw_cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (m_cyc_o) saw_cyc = 1;
            if (ack_o || err_o) begin
                got     = 1;
                got_err = err_o;
            end
        end
        rdat = dat_o;
        if (!got) begin
            chk("resp_wait_expired", 1'b0, 1'b1);
            exp_acc_q.delete();
            exp_resp_q.delete();
            dly_q.delete();
        end
        chk("latency", lat, exp_lat);
        // Hold the request through the ack cycle, then release it.
        @(posedge clk);
        #1;
        cyc_i      = 1'b0;
        stb_i      = 1'b0;
        slave_mute = 0;
        hold_valid = got && !mute;
        hold_dat   = exp_dat;
    endtask

    // Drops cyc_i right after the first strobe: only that byte may happen.
    task automatic do_abort(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        int         k0;
        logic [5:0] a;
        k0 = 0;
        for (int k = 3; k >= 0; k--) if (sel[k]) k0 = k;
        a = {adr, 2'(k0)};
        dly_q.push_back($urandom_range(0, 3));
        exp_acc_q.push_back({we, a, dat[8*k0 +: 8]});
        if (we) ref_mem[a] = dat[8*k0 +: 8];
        @(negedge clk);
        hold_valid = 0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        sel_i = sel;
        dat_i = dat;
        @(negedge clk);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_bytes_left", exp_acc_q.size(), 0);
        chk("abort_delays_left", dly_q.size(), 0);
    endtask

    // Reset while the first byte of a 4-lane read is waiting for its ack.
    task automatic reset_mid();
        exp_acc_q.push_back({1'b0, 4'h6, 2'd0, 8'h5a});
        dly_q.push_back(0);
        @(negedge clk);
        hold_valid = 0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = 4'h6;
        sel_i = 4'hf;
        dat_i = 32'h1234_565a;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            {dat_o, ack_o, err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o}, '0);
        chk("rst_mid_bytes", exp_acc_q.size(), 0);
        rst = 1'b0;
        exp_acc_q.delete();
        exp_resp_q.delete();
        dly_q.delete();
        hold_valid = 1;
        hold_dat   = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        logic [31:0] rd;
        bit          ge;
        bit          sc;
        int          mode;
        logic        r_we;
        logic [3:0]  r_adr;
        logic [3:0]  r_sel;
        logic [31:0] r_dat;
        n_cmp      = 0;
        n_bad      = 0;
        slave_mute = 0;
        hold_valid = 0;
        hold_dat   = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'($urandom());
            slv_mem[i] = ref_mem[i];
        end
        rst   = 1'b1;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = 4'h3;
        sel_i = 4'hf;
        dat_i = 32'hffff_ffff;

        // Reset with a request held: every output must stay at zero.
        repeat (4) begin
            @(negedge clk);
            chk("reset_outputs",
                {dat_o, ack_o, err_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o}, '0);
        end
        rst   = 1'b0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        hold_valid = 1;
        hold_dat   = '0;

        // Single-lane write.
        do_req(1'b1, 4'h2, 4'b0001, 32'h0000_00a5, 0, 0, lat, rd, ge, sc);
        chk("t2_latency", lat, 3);
        chk("t2_mem08", slv_mem[8], 8'ha5);

        // Full-word read, bytes returned in ascending address order.
        ref_mem[12] = 8'h11; ref_mem[13] = 8'h22; ref_mem[14] = 8'h33; ref_mem[15] = 8'h44;
        slv_mem[12] = 8'h11; slv_mem[13] = 8'h22; slv_mem[14] = 8'h33; slv_mem[15] = 8'h44;
        do_req(1'b0, 4'h3, 4'b1111, 32'h0, 0, 0, lat, rd, ge, sc);
        chk("t3_latency", lat, 9);
        chk("t3_data", rd, 32'h4433_2211);

        // Sparse write: lanes 0 and 2 only.
        do_req(1'b1, 4'h4, 4'b0101, 32'hdead_beef, 0, 0, lat, rd, ge, sc);
        chk("t4_latency", lat, 5);
        chk("t4_mem10", slv_mem[16], 8'hef);
        chk("t4_mem12", slv_mem[18], 8'had);
        chk("t4_mem11_untouched", slv_mem[17], ref_mem[17]);

        // Silent slave: error after TIMEOUT wait clocks, later lanes skipped.
        do_req(1'b0, 4'h5, 4'b0011, 32'h0, 0, 1, lat, rd, ge, sc);
        chk("t5_latency", lat, 10);
        chk("t5_err", ge, 1'b1);

        // No lanes selected.
        do_req(1'b0, 4'h7, 4'b0000, 32'h0, 0, 0, lat, rd, ge, sc);
        chk("t6a_latency", lat, 1);
        chk("t6a_data", rd, 32'h0);
        chk("t6a_no_cyc", sc, 1'b0);

        // Reset mid-transfer, then a normal request.
        reset_mid();
        do_req(1'b0, 4'h3, 4'b1111, 32'h0, 0, 0, lat, rd, ge, sc);
        chk("t6b_latency", lat, 9);
        chk("t6b_data", rd, 32'h4433_2211);

        // cyc_i dropped mid-transfer, then a normal request.
        do_abort(1'b0, 4'h3, 4'b1111, 32'h0);
        do_req(1'b1, 4'h1, 4'b1001, 32'hcafe_f00d, 1, 0, lat, rd, ge, sc);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            mode  = $urandom_range(0, 19);
            r_we  = 1'($urandom_range(0, 1));
            r_adr = 4'($urandom_range(0, 15));
            r_sel = 4'($urandom_range(0, 15));
            r_dat = $urandom();
            if (mode == 0) begin
                if (r_sel == 4'd0) r_sel = 4'b0001;
                do_req(r_we, r_adr, r_sel, r_dat, 0, 1, lat, rd, ge, sc);
            end else if (mode == 1) begin
                if (r_sel == 4'd0) r_sel = 4'b1000;
                do_abort(r_we, r_adr, r_sel, r_dat);
            end else begin
                do_req(r_we, r_adr, r_sel, r_dat, 3, 0, lat, rd, ge, sc);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("final_bytes_left", exp_acc_q.size(), 0);
        chk("final_resps_left", exp_resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
